pw_entry_buffer: RTL and testbench

//  Upstream stage of the password checker. Collects keypad digits into a

---
 rtl/pw_entry_buffer_if.sv | 25 ++
 rtl/pw_entry_buffer.sv | 176 +++++++++++++++++
 tb/tb_pw_entry_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pw_entry_buffer_if.sv
// Keypad-to-checker handshake bundle for pw_entry_buffer.
// The master drives keys and the checker finish level. The slave is the entry buffer.
interface pw_entry_buffer_if #(
  parameter int DIGITS = 4
);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic                  check_finish;
  logic [4*DIGITS-1:0]   code_out;
  logic                  start;
  logic                  busy;
  logic [2:0]            digit_count;
  logic                  entry_error;
  logic                  check_done;

  modport master (
    output key_valid, key_code, check_finish,
    input  code_out, start, busy, digit_count, entry_error, check_done
  );

  modport slave (
    input  key_valid, key_code, check_finish,
    output code_out, start, busy, digit_count, entry_error, check_done
  );
endinterface

// File: rtl/pw_entry_buffer.sv
// Keypad digit collector feeding the password checker: it builds a BCD code, starts the check,
// and waits for a fresh finish edge or a timeout before it accepts the next attempt.
module pw_entry_buffer #(
  parameter int DIGITS       = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic               clk,
  input  logic               rst,
  pw_entry_buffer_if.slave   bus
);

  localparam int W   = 4 * DIGITS;
  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TCW = $clog2(TIMEOUT);

  localparam logic [2:0]     FULL       = 3'(DIGITS);
  localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT - 1);

  localparam logic [3:0] KEY_BACK  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_START,
    ST_WAIT
  } state_t;

  state_t           r_state,     w_state;
  logic [W-1:0]     r_buf,       w_buf;
  logic [W-1:0]     r_code,      w_code;
  logic [2:0]       r_count,     w_count;
  logic             r_start,     w_start;
  logic             r_busy,      w_busy;
  logic             r_err,       w_err;
  logic             r_done,      w_done;
  logic [SCW-1:0]   r_start_cnt, w_start_cnt;
  logic [TCW-1:0]   r_to_cnt,    w_to_cnt;
  logic             r_fin_q;
  logic             r_seen_low,  w_seen_low;
  logic             w_complete;

  // A stale high finish from the previous check never produces a rising edge, because seen_low
  // stays clear until the finish input has been sampled low after this start.
  assign w_complete = bus.check_finish & ~r_fin_q & r_seen_low;

  // NOTE: every signal gets its hold/idle value before the case statement, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state     = r_state;
    w_buf       = r_buf;
    w_code      = r_code;
    w_count     = r_count;
    w_start     = r_start;
    w_busy      = r_busy;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_start_cnt = r_start_cnt;
    w_to_cnt    = r_to_cnt;
    w_seen_low  = r_seen_low | ~bus.check_finish;

    unique case (r_state)
      ST_ENTRY: begin
        w_start = 1'b0;
        w_busy  = 1'b0;
        if (bus.key_valid) begin
          if (bus.key_code <= 4'd9) begin
            if (r_count < FULL) begin
              w_buf   = {r_buf[W-5:0], bus.key_code};
              w_count = r_count + 3'd1;
            end else begin
              w_err = 1'b1;
            end
          end else if (bus.key_code == KEY_BACK) begin
            if (r_count != 3'd0) begin
              w_buf   = r_buf >> 4;
              w_count = r_count - 3'd1;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            w_buf   = '0;
            w_count = 3'd0;
          end else if (bus.key_code == KEY_ENTER) begin
            if (r_count == FULL) begin
              w_code      = r_buf;
              w_state     = ST_START;
              w_start     = 1'b1;
              w_busy      = 1'b1;
              w_start_cnt = '0;
              w_seen_low  = 1'b0;
            end else begin
              w_err   = 1'b1;
              w_buf   = '0;
              w_count = 3'd0;
            end
          end
        end
      end

      ST_START: begin
        w_busy = 1'b1;
        if (r_start_cnt == START_LAST) begin
          w_state  = ST_WAIT;
          w_start  = 1'b0;
          w_to_cnt = '0;
        end else begin
          w_start_cnt = r_start_cnt + 1'b1;
        end
      end

      ST_WAIT: begin
        w_start = 1'b0;
        w_busy  = 1'b1;
        // Completion is checked before the timeout so that a finish edge always wins.
        if (w_complete || (r_to_cnt == TO_LAST)) begin
          w_done  = w_complete;
          w_err   = ~w_complete;
          w_buf   = '0;
          w_code  = '0;
          w_count = 3'd0;
          w_busy  = 1'b0;
          w_state = ST_ENTRY;
        end else begin
          w_to_cnt = r_to_cnt + 1'b1;
        end
      end

      default: begin
        w_state = ST_ENTRY;
        w_start = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every register samples the values
  // from before the clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ENTRY;
      r_buf       <= '0;
      r_code      <= '0;
      r_count     <= 3'd0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_start_cnt <= '0;
      r_to_cnt    <= '0;
      r_fin_q     <= 1'b0;
      r_seen_low  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_buf       <= w_buf;
      r_code      <= w_code;
      r_count     <= w_count;
      r_start     <= w_start;
      r_busy      <= w_busy;
      r_err       <= w_err;
      r_done      <= w_done;
      r_start_cnt <= w_start_cnt;
      r_to_cnt    <= w_to_cnt;
      r_fin_q     <= bus.check_finish;
      r_seen_low  <= w_seen_low;
    end
  end

  assign bus.code_out    = r_code;
  assign bus.start       = r_start;
  assign bus.busy        = r_busy;
  assign bus.digit_count = r_count;
  assign bus.entry_error = r_err;
  assign bus.check_done  = r_done;

endmodule

// File: tb/tb_pw_entry_buffer.sv
// Directed bench for pw_entry_buffer: it covers entry, editing, the start/wait handshake,
// stale finish, timeout, dropped keys and mid-check reset.
module tb_pw_entry_buffer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  pw_entry_buffer_if #(.DIGITS(4)) bus ();

  pw_entry_buffer #(.DIGITS(4), .START_CYCLES(2), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 time unit after the active edge, and new inputs are applied at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.check_finish = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (bus.code_out !== 16'h0000) begin bad++; $display("FAIL reset_code got=%h exp=0000", bus.code_out); end
    total++; if ({bus.start, bus.busy, bus.entry_error, bus.check_done} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b exp=0000", {bus.start, bus.busy, bus.entry_error, bus.check_done}); end
    total++; if (bus.digit_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.digit_count); end
  endtask

  task automatic test_basic();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    total++; if (bus.digit_count !== 3'd4) begin bad++; $display("FAIL basic_count got=%0d exp=4", bus.digit_count); end
    press(4'hE);
    total++; if (bus.code_out !== 16'h1234) begin bad++; $display("FAIL basic_code got=%h exp=1234", bus.code_out); end
    total++; if ({bus.start, bus.busy} !== 2'b11) begin bad++; $display("FAIL basic_start1 got=%b exp=11", {bus.start, bus.busy}); end
    tick();
    total++; if ({bus.start, bus.busy} !== 2'b11) begin bad++; $display("FAIL basic_start2 got=%b exp=11", {bus.start, bus.busy}); end
    tick();
    total++; if ({bus.start, bus.busy} !== 2'b01) begin bad++; $display("FAIL basic_wait got=%b exp=01", {bus.start, bus.busy}); end
    tick(); tick();
    bus.check_finish = 1'b1;
    tick();
    total++; if ({bus.check_done, bus.entry_error, bus.busy} !== 3'b100) begin bad++;
      $display("FAIL basic_done got=%b exp=100", {bus.check_done, bus.entry_error, bus.busy}); end
    total++; if (bus.code_out !== 16'h0000) begin bad++; $display("FAIL basic_clear got=%h exp=0000", bus.code_out); end
    bus.check_finish = 1'b0;
    tick();
    total++; if (bus.check_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", bus.check_done); end
  endtask

  task automatic test_edit();
    press(4'h5); press(4'h6); press(4'hA);
    total++; if (bus.digit_count !== 3'd1) begin bad++; $display("FAIL edit_back_count got=%0d exp=1", bus.digit_count); end
    press(4'hC);
    total++; if ({bus.digit_count, bus.entry_error} !== {3'd1, 1'b0}) begin bad++;
      $display("FAIL edit_ignore got=%0d/%b exp=1/0", bus.digit_count, bus.entry_error); end
    press(4'h7); press(4'h8); press(4'h9); press(4'hE);
    total++; if (bus.code_out !== 16'h5789) begin bad++; $display("FAIL edit_code got=%h exp=5789", bus.code_out); end
    total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL edit_start got=%b exp=1", bus.start); end
    tick(); tick();
    bus.check_finish = 1'b1;
    tick();
    total++; if (bus.check_done !== 1'b1) begin bad++; $display("FAIL edit_done got=%b exp=1", bus.check_done); end
    bus.check_finish = 1'b0;
    tick();
    press(4'h1); press(4'h2); press(4'hB);
    total++; if (bus.digit_count !== 3'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", bus.digit_count); end
    press(4'hE);
    total++; if ({bus.entry_error, bus.start, bus.busy} !== 3'b100) begin bad++;
      $display("FAIL bad_enter got=%b exp=100", {bus.entry_error, bus.start, bus.busy}); end
    tick();
    total++; if ({bus.entry_error, bus.start} !== 2'b00) begin bad++; $display("FAIL bad_enter_after got=%b exp=00", {bus.entry_error, bus.start}); end
    press(4'hA);
    total++; if ({bus.digit_count, bus.entry_error} !== {3'd0, 1'b0}) begin bad++;
      $display("FAIL back_empty got=%0d/%b exp=0/0", bus.digit_count, bus.entry_error); end
  endtask

  task automatic test_overflow();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    total++; if ({bus.entry_error, bus.digit_count} !== {1'b1, 3'd4}) begin bad++;
      $display("FAIL overflow got=%b/%0d exp=1/4", bus.entry_error, bus.digit_count); end
    tick();
    press(4'hE);
    total++; if ({bus.code_out, bus.start} !== {16'h1234, 1'b1}) begin bad++;
      $display("FAIL overflow_enter got=%h/%b exp=1234/1", bus.code_out, bus.start); end
    tick(); tick();
    bus.check_finish = 1'b1;
    tick();
    total++; if (bus.check_done !== 1'b1) begin bad++; $display("FAIL overflow_done got=%b exp=1", bus.check_done); end
    tick();
  endtask

  task automatic test_stale_and_timeout();
    // check_finish is still high from the previous check.
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hE);
    total++; if (bus.code_out !== 16'h9876) begin bad++; $display("FAIL stale_code got=%h exp=9876", bus.code_out); end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({bus.check_done, bus.busy} !== 2'b01) begin bad++;
        $display("FAIL stale_hold[%0d] got=%b exp=01", i, {bus.check_done, bus.busy}); end
    end
    bus.check_finish = 1'b0;
    tick();
    total++; if (bus.check_done !== 1'b0) begin bad++; $display("FAIL stale_low got=%b exp=0", bus.check_done); end
    bus.check_finish = 1'b1;
    tick();
    total++; if ({bus.check_done, bus.entry_error, bus.busy} !== 3'b100) begin bad++;
      $display("FAIL stale_done got=%b exp=100", {bus.check_done, bus.entry_error, bus.busy}); end
    bus.check_finish = 1'b0;
    tick();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
    tick(); tick();
    // The wait phase lasts 15 cycles. Busy must hold for the first 14, then the timeout fires.
    for (int i = 0; i < 14; i++) begin
      tick();
      total++; if ({bus.busy, bus.entry_error} !== 2'b10) begin bad++;
        $display("FAIL timeout_wait[%0d] got=%b exp=10", i, {bus.busy, bus.entry_error}); end
    end
    tick();
    total++; if ({bus.entry_error, bus.check_done, bus.busy} !== 3'b100) begin bad++;
      $display("FAIL timeout got=%b exp=100", {bus.entry_error, bus.check_done, bus.busy}); end
    total++; if ({bus.code_out, bus.digit_count} !== {16'h0000, 3'd0}) begin bad++;
      $display("FAIL timeout_clear got=%h/%0d exp=0000/0", bus.code_out, bus.digit_count); end
    tick();
  endtask

  task automatic test_busy_keys();
    press(4'h5); press(4'h5); press(4'h5); press(4'h5); press(4'hE);
    press(4'h1);
    press(4'h2);
    press(4'hB);
    press(4'hE);
    total++; if ({bus.digit_count, bus.code_out} !== {3'd4, 16'h5555}) begin bad++;
      $display("FAIL busy_keys got=%0d/%h exp=4/5555", bus.digit_count, bus.code_out); end
    total++; if ({bus.start, bus.busy, bus.entry_error} !== 3'b010) begin bad++;
      $display("FAIL busy_keys_flags got=%b exp=010", {bus.start, bus.busy, bus.entry_error}); end
    bus.check_finish = 1'b1;
    tick();
    total++; if (bus.check_done !== 1'b1) begin bad++; $display("FAIL busy_done got=%b exp=1", bus.check_done); end
    bus.check_finish = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hE);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    total++; if ({bus.code_out, bus.digit_count, bus.start, bus.busy, bus.entry_error, bus.check_done} !== 23'd0) begin bad++;
      $display("FAIL mid_reset got=%h/%0d/%b exp=0000/0/0000", bus.code_out, bus.digit_count,
               {bus.start, bus.busy, bus.entry_error, bus.check_done}); end
    rst = 1'b0;
    press(4'h1); press(4'h1); press(4'h1); press(4'h1); press(4'hE);
    total++; if ({bus.code_out, bus.start} !== {16'h1111, 1'b1}) begin bad++;
      $display("FAIL after_reset got=%h/%b exp=1111/1", bus.code_out, bus.start); end
    tick(); tick();
    bus.check_finish = 1'b1;
    tick();
    total++; if (bus.check_done !== 1'b1) begin bad++; $display("FAIL after_reset_done got=%b exp=1", bus.check_done); end
    bus.check_finish = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edit();
    test_overflow();
    test_stale_and_timeout();
    test_busy_keys();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
